// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, defaults, FIFO entry layout.
// Optional misaligned-redirect halt is enabled with FETCH_MISALIGN_CHECK_EN.
package inst_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] PC_INC             = 32'h0000_0004;
  localparam int          DEFAULT_FIFO_DEPTH = 2;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction
`endif

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Instruction buffer holding {pc, instr} entries; registered head, no fall-through.
// Flush has priority over push/pop; push into a full buffer is allowed only alongside a pop.
module inst_fetch_unit_fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_data,
  output fetch_entry_t           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (count_r == {(AW+1){1'b0}});
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];

  // Entry storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// PC generator and instruction fetcher: sequential word fetches over req/ack, buffered to decode.
// Define FETCH_MISALIGN_CHECK_EN to halt (sticky o_misalign) on a misaligned redirect target.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_r;
  fetch_state_e  state_nxt_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   fetch_pc_nxt_s;
  logic [31:0]   addr_r;
  logic [31:0]   addr_nxt_s;
  logic          req_r;
  logic          req_nxt_s;
  logic          ack_s;
  logic          push_s;
  logic          pop_s;
  logic          flush_s;
  logic          outstanding_nxt_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_nxt_s;
  logic          full_s;
  logic          empty_s;
  fetch_entry_t  head_s;
  fetch_entry_t  wr_entry_s;

  // An ack only counts while a request is actually outstanding (stray acks after reset are ignored).
  assign ack_s             = i_imem_ack & req_r;
  assign pop_s             = ~empty_s & i_instr_ready;
  assign outstanding_nxt_s = req_r & ~ack_s;
  assign wr_entry_s        = {fetch_pc_r, i_imem_rdata};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_r;
  logic misalign_nxt_s;
  logic bad_redirect_s;
  assign bad_redirect_s = i_redirect_valid & pc_misaligned(i_redirect_pc);
  assign o_misalign     = misalign_r;
`else
  assign o_misalign = 1'b0;
`endif

  // FSM next state, fetch PC update, FIFO push/flush.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    push_s         = 1'b0;
    flush_s        = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_nxt_s = misalign_r;
`endif
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
        if (i_redirect_valid) begin
          fetch_pc_nxt_s = align_pc(i_redirect_pc);
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
      end
      ST_FETCH: begin
        if (i_redirect_valid) begin
          fetch_pc_nxt_s = align_pc(i_redirect_pc);
          flush_s        = 1'b1;
          if (outstanding_nxt_s) begin
            state_nxt_s = ST_DISCARD;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else if (ack_s) begin
          push_s         = 1'b1;
          fetch_pc_nxt_s = fetch_pc_r + PC_INC;
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
      end
      ST_DISCARD: begin
        // The ack of the stale request is dropped; a further redirect only retargets.
        if (i_redirect_valid) begin
          fetch_pc_nxt_s = align_pc(i_redirect_pc);
          flush_s        = 1'b1;
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
        if (ack_s) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (bad_redirect_s && (state_r != ST_HALT)) begin
      state_nxt_s    = ST_HALT;
      misalign_nxt_s = 1'b1;
      flush_s        = 1'b1;
      push_s         = 1'b0;
      fetch_pc_nxt_s = fetch_pc_r;
    end else begin
      misalign_nxt_s = misalign_r | 1'b0;
    end
`endif
  end

  // Request generation: keep count + outstanding within the buffer depth, hold req/addr until ack.
  always_comb begin
    count_nxt_s = count_s;
    req_nxt_s   = 1'b0;
    addr_nxt_s  = addr_r;
    if (flush_s) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      count_nxt_s = count_s + CW'(push_s & (~full_s | pop_s)) - CW'(pop_s);
    end
    case (state_nxt_s)
      ST_FETCH:   req_nxt_s = outstanding_nxt_s | (count_nxt_s < CW'(FIFO_DEPTH));
      ST_DISCARD: req_nxt_s = outstanding_nxt_s;
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_HALT:    req_nxt_s = outstanding_nxt_s;
`endif
      default:    req_nxt_s = 1'b0;
    endcase
    if (outstanding_nxt_s) begin
      addr_nxt_s = addr_r;
    end else begin
      addr_nxt_s = fetch_pc_nxt_s;
    end
  end

  // State, PC and request registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      addr_r     <= RESET_PC;
      req_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      addr_r     <= addr_nxt_s;
      req_r      <= req_nxt_s;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_nxt_s;
    end
  end
`endif

  inst_fetch_unit_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush_s),
    .wr_data (wr_entry_s),
    .rd_data (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign o_imem_req    = req_r;
  assign o_imem_addr   = addr_r;
  assign o_instr_valid = ~empty_s;
  assign o_instr       = head_s.instr;
  assign o_instr_pc    = head_s.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: memory responder + scoreboard of fetched words,
// a table of redirect scenarios, and hand-written reset/wrap/discard sequences.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET = 32'h0000_0000;
  localparam int          DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic [31:0] target;
    int          mode;     // 1: now, 2: with an ack, 3: while a request is held
    int          lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
  } rvec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_misalign;

  inst_fetch_unit #(.RESET_PC(RESET), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ack       (i_imem_ack),
    .i_imem_rdata     (i_imem_rdata),
    .o_instr_valid    (o_instr_valid),
    .o_instr          (o_instr),
    .o_instr_pc       (o_instr_pc),
    .i_instr_ready    (i_instr_ready),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_misalign       (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          failures = 0;
  ent_t        sb[$];
  logic [31:0] pc_log[$];
  logic [31:0] exp_pc = RESET;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] redir_target = 32'h0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_pc = 32'h0;
  bit          held = 1'b0;
  bit          stale = 1'b0;
  bit          halted = 1'b0;
  bit          watch_req = 1'b0;
  bit          watch_pop = 1'b0;
  bit          ready_cfg = 1'b1;
  int          redir_mode = 0;
  int          ack_lat = 0;
  int          wcnt = 0;
  int          ack_cnt = 0;
  rvec_t       vecs[5];

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_log(input int idx, input logic [31:0] exp, input string nm);
    if (pc_log.size() > idx) chk(pc_log[idx] == exp, nm, pc_log[idx], exp);
    else chk(1'b0, nm, 32'(pc_log.size()), exp);
  endtask

  // One clock: check outputs, answer memory, consume head, maybe redirect, update the model.
  task automatic tick();
    ent_t e;
    bit   go;
    @(negedge i_clk);
    chk(o_instr_valid == (sb.size() != 0), "instr_valid", 32'(o_instr_valid), 32'(sb.size() != 0));
    chk(o_misalign == halted, "misalign", 32'(o_misalign), 32'(halted));
    if (held) begin
      chk(o_imem_req && (o_imem_addr == held_addr), "req_hold", o_imem_addr, held_addr);
    end else if (halted) begin
      chk(!o_imem_req, "halt_no_req", 32'(o_imem_req), 32'h0);
    end else if (o_imem_req) begin
      chk(o_imem_addr == exp_pc, "req_addr", o_imem_addr, exp_pc);
      chk(sb.size() < DEPTH, "req_when_full", 32'(sb.size()), 32'(DEPTH - 1));
      if (watch_req) begin
        cap_addr  = o_imem_addr;
        watch_req = 1'b0;
      end
    end
    i_imem_ack = 1'b0;
    if (o_imem_req) begin
      if (wcnt >= ack_lat) begin
        i_imem_ack   = 1'b1;
        i_imem_rdata = $urandom();
        wcnt         = 0;
        ack_cnt++;
      end else begin
        wcnt++;
      end
    end
    i_instr_ready = ready_cfg;
    if (o_instr_valid && i_instr_ready) begin
      if (sb.size() == 0) begin
        chk(1'b0, "pop_unexpected", o_instr_pc, 32'h0);
      end else begin
        e = sb.pop_front();
        chk(o_instr_pc == e.pc, "instr_pc", o_instr_pc, e.pc);
        chk(o_instr == e.instr, "instr", o_instr, e.instr);
      end
      pc_log.push_back(o_instr_pc);
      if (watch_pop) begin
        cap_pc    = o_instr_pc;
        watch_pop = 1'b0;
      end
    end
    case (redir_mode)
      1:       go = 1'b1;
      2:       go = i_imem_ack;
      3:       go = o_imem_req && !i_imem_ack;
      default: go = 1'b0;
    endcase
    i_redirect_valid = go;
    i_redirect_pc    = redir_target;
    if (i_imem_ack) begin
      if (go || stale || halted) begin
        stale = 1'b0;
      end else begin
        sb.push_back({o_imem_addr, i_imem_rdata});
        exp_pc = exp_pc + 32'd4;
      end
    end
    held      = o_imem_req && !i_imem_ack;
    held_addr = o_imem_addr;
    if (go) begin
      redir_mode = 0;
      sb.delete();
      pc_log.delete();
      watch_req = 1'b1;
      watch_pop = 1'b1;
      if (held) stale = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redir_target[1:0] != 2'b00) halted = 1'b1;
`endif
      exp_pc = redir_target & 32'hFFFF_FFFC;
    end
  endtask

  // Asynchronous reset mid-cycle with a stray ack driven through reset and the IDLE cycle.
  task automatic do_reset();
    #2;
    i_rst            = 1'b1;
    i_imem_ack       = 1'b1;
    i_imem_rdata     = 32'hDEAD_BEEF;
    i_redirect_valid = 1'b0;
    #1;
    chk(o_imem_req == 1'b0, "rst_req", 32'(o_imem_req), 32'h0);
    chk(o_instr_valid == 1'b0, "rst_valid", 32'(o_instr_valid), 32'h0);
    chk(o_misalign == 1'b0, "rst_misalign", 32'(o_misalign), 32'h0);
    chk(o_imem_addr == RESET, "rst_addr", o_imem_addr, RESET);
    chk(o_instr == 32'h0, "rst_instr", o_instr, 32'h0);
    chk(o_instr_pc == 32'h0, "rst_instr_pc", o_instr_pc, 32'h0);
    sb.delete();
    pc_log.delete();
    held = 1'b0; stale = 1'b0; halted = 1'b0;
    watch_req = 1'b0; watch_pop = 1'b0;
    redir_mode = 0; wcnt = 0; exp_pc = RESET;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic run_redirect(input logic [31:0] tgt, input int mode);
    redir_target = tgt;
    redir_mode   = mode;
    for (int k = 0; k < 80; k++) begin
      if (redir_mode == 0 && !watch_req && !watch_pop) break;
      tick();
    end
    chk(redir_mode == 0 && !watch_req && !watch_pop, "redir_timeout", 32'(redir_mode), 32'h0);
  endtask

  initial begin
    vecs[0] = '{target: 32'h0000_0100, mode: 3, lat: 3, exp_addr: 32'h0000_0100, exp_pc: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_0200, mode: 2, lat: 1, exp_addr: 32'h0000_0200, exp_pc: 32'h0000_0200};
    vecs[2] = '{target: 32'h0000_0300, mode: 1, lat: 0, exp_addr: 32'h0000_0300, exp_pc: 32'h0000_0300};
    vecs[3] = '{target: 32'h0000_0404, mode: 3, lat: 2, exp_addr: 32'h0000_0404, exp_pc: 32'h0000_0404};
    vecs[4] = '{target: 32'hFFFF_FFF8, mode: 1, lat: 0, exp_addr: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8};

    // Streaming with immediate acks and ready decode.
    do_reset();
    ack_lat = 0; ready_cfg = 1'b1;
    repeat (12) tick();
    check_log(0, 32'h0000_0000, "seq_pc0");
    check_log(1, 32'h0000_0004, "seq_pc1");
    check_log(2, 32'h0000_0008, "seq_pc2");

    // Decode stalled: buffer fills to depth and requests stop, then drains in order.
    do_reset();
    ready_cfg = 1'b0; ack_cnt = 0;
    repeat (10) tick();
    chk(ack_cnt == DEPTH, "fill_count", 32'(ack_cnt), 32'(DEPTH));
    chk(o_imem_req == 1'b0, "full_no_req", 32'(o_imem_req), 32'h0);
    ready_cfg = 1'b1;
    repeat (4) tick();
    check_log(0, 32'h0000_0000, "drain_pc0");
    check_log(1, 32'h0000_0004, "drain_pc1");

    // Redirect table: held request, coincident ack, idle redirect, wrap-around target.
    for (int v = 0; v < 5; v++) begin
      ack_lat = vecs[v].lat;
      repeat (3) tick();
      run_redirect(vecs[v].target, vecs[v].mode);
      chk(cap_addr == vecs[v].exp_addr, $sformatf("redir%0d_addr", v), cap_addr, vecs[v].exp_addr);
      chk(cap_pc == vecs[v].exp_pc, $sformatf("redir%0d_pc", v), cap_pc, vecs[v].exp_pc);
    end
    repeat (8) tick();
    check_log(0, 32'hFFFF_FFF8, "wrap_pc0");
    check_log(1, 32'hFFFF_FFFC, "wrap_pc1");
    check_log(2, 32'h0000_0000, "wrap_pc2");

    // Second redirect while still discarding only retargets.
    ack_lat = 6;
    repeat (3) tick();
    redir_target = 32'h0000_0500;
    redir_mode   = 3;
    for (int k = 0; k < 20 && redir_mode != 0; k++) tick();
    chk(redir_mode == 0, "discard_first", 32'(redir_mode), 32'h0);
    tick();
    run_redirect(32'h0000_0600, 3);
    chk(cap_addr == 32'h0000_0600, "discard_retarget", cap_addr, 32'h0000_0600);

    // Misaligned redirect target.
    ack_lat = 1;
    repeat (4) tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    redir_target = 32'h0000_0102;
    redir_mode   = 1;
    repeat (12) tick();
    chk(o_misalign == 1'b1, "misalign_set", 32'(o_misalign), 32'h1);
    chk(o_imem_req == 1'b0, "misalign_halt", 32'(o_imem_req), 32'h0);
`else
    run_redirect(32'h0000_0102, 1);
    chk(cap_addr == 32'h0000_0100, "misalign_addr", cap_addr, 32'h0000_0100);
    chk(cap_pc == 32'h0000_0100, "misalign_pc", cap_pc, 32'h0000_0100);
`endif

    // Reset in the middle of traffic, then restart from the reset PC.
    do_reset();
    ack_lat = 1;
    repeat (8) tick();
    check_log(0, RESET, "post_reset_pc0");
    check_log(1, RESET + 32'd4, "post_reset_pc1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
